// File: rtl/portcullis_pkg.sv
// Shared state encoding, station indices and sizing helper for the portcullis scheduler.
package portcullis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_RAISE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LOWER = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam int STN_IN  = 0;
    localparam int STN_OUT = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/portcullis_scheduler_if.sv
// Station requests, limit switches and motor/status outputs of the portcullis scheduler.
interface portcullis_scheduler_if;
    logic       REQ_IN;
    logic       REQ_OUT;
    logic       UP_LMT;
    logic       DW_LMT;
    logic       FLT_CLR;
    logic       MOT_UP;
    logic       MOT_DW;
    logic [1:0] GRANT;
    logic       BUSY;
    logic       FAULT;

    modport master (
        output REQ_IN, REQ_OUT, UP_LMT, DW_LMT, FLT_CLR,
        input  MOT_UP, MOT_DW, GRANT, BUSY, FAULT
    );

    modport slave (
        input  REQ_IN, REQ_OUT, UP_LMT, DW_LMT, FLT_CLR,
        output MOT_UP, MOT_DW, GRANT, BUSY, FAULT
    );
endinterface

// File: rtl/cycle_timer.sv
// Saturating cycle counter shared by the timed states; clr wins over en.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            r_count <= '0;
        else if (en && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;
endmodule

// File: rtl/portcullis_scheduler.sv
// Gate sequencer: round-robin station grant, dead time before every motor start,
// hold at the top, reversal while lowering, and latched fault on timeout or sensor conflict.
module portcullis_scheduler
    import portcullis_pkg::*;
#(
    parameter int DEAD_TIME   = 4,
    parameter int HOLD_TIME   = 1000,
    parameter int RUN_TIMEOUT = 5000
) (
    input  logic                   clk,
    input  logic                   rst,
    portcullis_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(max3(DEAD_TIME, HOLD_TIME, RUN_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIME - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic             r_dir_up, w_dir_up_nxt;
    logic [1:0]       r_grant, w_grant_nxt;
    logic             r_last_out, w_last_out_nxt;
    logic             r_req_in_q, r_req_out_q, r_evt_mask;
    logic             w_ev_in, w_ev_out, w_ev_any, w_pick_out, w_conflict;
    logic             w_take, w_restart, w_clr, w_en;
    logic [1:0]       w_win;
    logic [CNT_W-1:0] w_cnt;

    // The mask blocks the first edge after reset so a request held through reset is not an event.
    assign w_ev_in    = bus.REQ_IN  & ~r_req_in_q  & ~r_evt_mask;
    assign w_ev_out   = bus.REQ_OUT & ~r_req_out_q & ~r_evt_mask;
    assign w_ev_any   = w_ev_in | w_ev_out;
    assign w_pick_out = w_ev_out & (~w_ev_in | ~r_last_out);
    assign w_win      = w_pick_out ? 2'(1 << STN_OUT) : 2'(1 << STN_IN);
    assign w_conflict = bus.UP_LMT & bus.DW_LMT;

    assign w_en  = (r_state == ST_DEAD) || (r_state == ST_RAISE) ||
                   (r_state == ST_HOLD) || (r_state == ST_LOWER);
    assign w_clr = (w_state_nxt != r_state) || w_restart;

    cycle_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .count (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dir_up    <= 1'b1;
            r_grant     <= 2'b00;
            r_last_out  <= 1'b1;
            r_req_in_q  <= 1'b0;
            r_req_out_q <= 1'b0;
            r_evt_mask  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_grant     <= w_grant_nxt;
            r_last_out  <= w_last_out_nxt;
            r_req_in_q  <= bus.REQ_IN;
            r_req_out_q <= bus.REQ_OUT;
            r_evt_mask  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dir_up_nxt   = r_dir_up;
        w_grant_nxt    = r_grant;
        w_last_out_nxt = r_last_out;
        w_restart      = 1'b0;
        w_take         = 1'b0;
        if ((r_state != ST_FAULT) && w_conflict) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: if (w_ev_any) begin
                    w_take = 1'b1;
                    if (bus.UP_LMT) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt  = ST_DEAD;
                        w_dir_up_nxt = 1'b1;
                    end
                end
                ST_DEAD: if (w_cnt == DEAD_LAST) begin
                    w_state_nxt = r_dir_up ? ST_RAISE : ST_LOWER;
                end else if (w_ev_any) begin
                    w_take = 1'b1;
                    if (!r_dir_up) begin
                        w_dir_up_nxt = 1'b1;
                        w_restart    = 1'b1;
                    end
                end
                ST_RAISE: if (bus.UP_LMT) w_state_nxt = ST_HOLD;
                    else if (w_cnt == RUN_LAST) w_state_nxt = ST_FAULT;
                    else if (w_ev_any) w_take = 1'b1;
                ST_HOLD: if (w_cnt == HOLD_LAST) begin
                    w_state_nxt  = ST_DEAD;
                    w_dir_up_nxt = 1'b0;
                end else if (w_ev_any) begin
                    w_take    = 1'b1;
                    w_restart = 1'b1;
                end
                ST_LOWER: if (bus.DW_LMT) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                end else if (w_cnt == RUN_LAST) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_ev_any) begin
                    w_take       = 1'b1;
                    w_state_nxt  = ST_DEAD;
                    w_dir_up_nxt = 1'b1;
                end
                ST_FAULT: if (bus.FLT_CLR && !w_conflict) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_take) begin
            w_grant_nxt    = w_win;
            w_last_out_nxt = w_pick_out;
        end
    end

    always_comb begin
        bus.MOT_UP = (r_state == ST_RAISE);
        bus.MOT_DW = (r_state == ST_LOWER);
        bus.BUSY   = w_en;
        bus.FAULT  = (r_state == ST_FAULT);
        bus.GRANT  = r_grant;
    end
endmodule
